alarm_beeper: RTL and testbench

- Downstream consumer of the countdown timer in the top-level application.
- Watches the timer's running flag and seconds value, detects expiry (run stops with zero seconds left), and drives a passive buzzer with grouped beeps.
- Grouped beeps: BEEP_COUNT tone bursts per group, then a silent gap, for up to GROUPS groups.
- Any debounced button key-up or a timer restart silences it. Paced by the existing 1 ms refresh tick; tone generated from the system clock.

---
 rtl/alarm_beeper.sv | 162 ++++++++++++++++
 tb/tb_alarm_beeper.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alarm_beeper.sv
// alarm_beeper: watches the countdown timer, detects expiry (run flag falls
// while the seconds value is zero) and drives a passive buzzer with grouped
// beeps: BEEP_COUNT tone bursts per group, a silent gap, up to GROUPS groups.
// A key-up acknowledge or a timer restart silences it.
//
// Ports:
//   CLK        system clock
//   CLR        asynchronous active-low reset
//   CE         global clock enable; all state holds while low
//   MS_CE      1 ms tick, one CLK wide
//   IS_RUNNING countdown timer running flag
//   SECS       countdown timer remaining seconds
//   ACK        OR of debounced key-up pulses, one CLK wide
//   BUZZ       buzzer square wave
//   ALARM      high while the alarm sequence is active
//   BEEPING    high during a tone burst
module alarm_beeper #(
    parameter int unsigned SECS_BITS        = 16,
    parameter int unsigned TONE_HALF_PERIOD = 25000,
    parameter int unsigned BEEP_ON_MS       = 200,
    parameter int unsigned BEEP_OFF_MS      = 200,
    parameter int unsigned BEEP_COUNT       = 3,
    parameter int unsigned GROUP_GAP_MS     = 1000,
    parameter int unsigned GROUPS           = 10
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic                 CE,
    input  logic                 MS_CE,
    input  logic                 IS_RUNNING,
    input  logic [SECS_BITS-1:0] SECS,
    input  logic                 ACK,
    output logic                 BUZZ,
    output logic                 ALARM,
    output logic                 BEEPING
);

    localparam int unsigned MS_MAX0 = (BEEP_ON_MS > BEEP_OFF_MS) ? BEEP_ON_MS : BEEP_OFF_MS;
    localparam int unsigned MS_MAX  = (MS_MAX0 > GROUP_GAP_MS) ? MS_MAX0 : GROUP_GAP_MS;
    localparam int unsigned MS_W    = $clog2(MS_MAX + 1);
    localparam int unsigned TONE_W  = (TONE_HALF_PERIOD > 1) ? $clog2(TONE_HALF_PERIOD) : 1;
    localparam int unsigned BEEP_W  = $clog2(BEEP_COUNT + 1);
    localparam int unsigned GRP_W   = $clog2(GROUPS + 1);

    localparam logic [MS_W-1:0]   ON_LAST   = MS_W'(BEEP_ON_MS - 1);
    localparam logic [MS_W-1:0]   OFF_LAST  = MS_W'(BEEP_OFF_MS - 1);
    localparam logic [MS_W-1:0]   GAP_LAST  = MS_W'(GROUP_GAP_MS - 1);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

    state_t            state;
    logic              running_q;
    logic [MS_W-1:0]   ms_cnt;
    logic [TONE_W-1:0] tone_cnt;
    logic [BEEP_W-1:0] beep_cnt;
    logic [GRP_W-1:0]  grp_cnt;
    logic              expire;
    logic              restart;

    always_comb begin
        expire  = running_q & ~IS_RUNNING & (SECS == '0);
        restart = ~running_q & IS_RUNNING;
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state     <= IDLE;
            running_q <= 1'b0;
            ms_cnt    <= '0;
            tone_cnt  <= '0;
            beep_cnt  <= '0;
            grp_cnt   <= '0;
            BUZZ      <= 1'b0;
            ALARM     <= 1'b0;
            BEEPING   <= 1'b0;
        end else if (CE) begin
            running_q <= IS_RUNNING;

            // Outputs follow the registered state, one cycle behind the decision.
            ALARM   <= (state != IDLE);
            BEEPING <= (state == ON);

            // Tone runs only while in ON; any other state clears it so a new
            // burst always starts from a low half-period.
            if (state == ON) begin
                if (tone_cnt == TONE_LAST) begin
                    tone_cnt <= '0;
                    BUZZ     <= ~BUZZ;
                end else begin
                    tone_cnt <= tone_cnt + 1'b1;
                end
            end else begin
                tone_cnt <= '0;
                BUZZ     <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (expire && !ACK) begin
                        state    <= ON;
                        ms_cnt   <= '0;
                        beep_cnt <= '0;
                        grp_cnt  <= '0;
                    end
                end
                ON: begin
                    if (ACK || restart) begin
                        state  <= IDLE;
                        ms_cnt <= '0;
                    end else if (MS_CE) begin
                        if (ms_cnt == ON_LAST) begin
                            ms_cnt   <= '0;
                            beep_cnt <= beep_cnt + 1'b1;
                            if (32'(beep_cnt) + 32'd1 < BEEP_COUNT) state <= OFF;
                            else                                    state <= GAP;
                        end else begin
                            ms_cnt <= ms_cnt + 1'b1;
                        end
                    end
                end
                OFF: begin
                    if (ACK || restart) begin
                        state  <= IDLE;
                        ms_cnt <= '0;
                    end else if (MS_CE) begin
                        if (ms_cnt == OFF_LAST) begin
                            ms_cnt <= '0;
                            state  <= ON;
                        end else begin
                            ms_cnt <= ms_cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (ACK || restart) begin
                        state  <= IDLE;
                        ms_cnt <= '0;
                    end else if (MS_CE) begin
                        if (ms_cnt == GAP_LAST) begin
                            ms_cnt  <= '0;
                            grp_cnt <= grp_cnt + 1'b1;
                            if (32'(grp_cnt) + 32'd1 < GROUPS) begin
                                state    <= ON;
                                beep_cnt <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            ms_cnt <= ms_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    ms_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_beeper.sv
// Directed bench for alarm_beeper with small timing parameters.
// Timeline convention: t=0 is the edge where expiry is detected; MS_CE is
// sampled high at edges t = 5, 15, 25, ... so the state changes at
// ON->OFF 25, OFF->ON 45, ON->GAP 75, GAP->ON 125, ON->OFF 155, OFF->ON 175,
// ON->GAP 205, GAP->IDLE 255. Outputs are observed #1 after each edge and
// reflect the state held before that edge.
module tb_alarm_beeper;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        CE = 1'b1;
    logic        MS_CE = 1'b0;
    logic        IS_RUNNING = 1'b0;
    logic [15:0] SECS = 16'd0;
    logic        ACK = 1'b0;
    logic        BUZZ;
    logic        ALARM;
    logic        BEEPING;

    int unsigned ms_phase = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    alarm_beeper #(
        .SECS_BITS(16),
        .TONE_HALF_PERIOD(4),
        .BEEP_ON_MS(3),
        .BEEP_OFF_MS(2),
        .BEEP_COUNT(2),
        .GROUP_GAP_MS(5),
        .GROUPS(2)
    ) dut (
        .CLK(CLK),
        .CLR(CLR),
        .CE(CE),
        .MS_CE(MS_CE),
        .IS_RUNNING(IS_RUNNING),
        .SECS(SECS),
        .ACK(ACK),
        .BUZZ(BUZZ),
        .ALARM(ALARM),
        .BEEPING(BEEPING)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b time=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock with MS_CE every 10th cycle; outputs are observed #1 after the edge.
    task automatic step();
        MS_CE = (ms_phase == 9);
        @(posedge CLK);
        #1;
        ms_phase = (ms_phase + 1) % 10;
        MS_CE = 1'b0;
    endtask

    // Hand-derived expected outputs after edge t of a full alarm sequence.
    function automatic void expected(input int t, output logic ea, output logic eb, output logic ez);
        int s_tab[4] = '{0, 45, 125, 175};
        int x_tab[4] = '{25, 75, 155, 205};
        ea = (t >= 1) && (t <= 255);
        eb = 1'b0;
        ez = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (t >= s_tab[i] + 1 && t <= x_tab[i]) begin
                eb = 1'b1;
                ez = (((t - s_tab[i]) / 4) % 2) == 1;
            end
        end
    endfunction

    task automatic run_seq(input int first_t, input int last_t);
        logic ea, eb, ez;
        for (int t = first_t; t <= last_t; t++) begin
            step();
            expected(t, ea, eb, ez);
            check($sformatf("alarm@t%0d", t), ALARM, ea);
            check($sformatf("beeping@t%0d", t), BEEPING, eb);
            check($sformatf("buzz@t%0d", t), BUZZ, ez);
        end
    endtask

    // Running -> stopped at zero; the second step lands on edge t=0.
    task automatic start_expiry();
        IS_RUNNING = 1'b1;
        SECS = 16'd5;
        step();
        SECS = 16'd0;
        IS_RUNNING = 1'b0;
        ms_phase = 4;
        step();
        check("alarm@t0", ALARM, 1'b0);
        check("beeping@t0", BEEPING, 1'b0);
    endtask

    initial begin
        // Reset state
        #2 CLR = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("rst_alarm", ALARM, 1'b0);
        check("rst_beeping", BEEPING, 1'b0);
        check("rst_buzz", BUZZ, 1'b0);
        CLR = 1'b1;
        repeat (3) step();
        check("idle_alarm", ALARM, 1'b0);

        // Full expiry sequence: two groups of ON3/OFF2/ON3/GAP5, then idle
        start_expiry();
        run_seq(1, 265);

        // Pause with seconds remaining never alarms
        IS_RUNNING = 1'b1;
        SECS = 16'd37;
        step();
        IS_RUNNING = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            check("pause_alarm", ALARM, 1'b0);
        end
        SECS = 16'd0;
        repeat (20) step();
        check("pause_then_zero_alarm", ALARM, 1'b0);

        // ACK coincident with expiry in IDLE keeps it idle
        IS_RUNNING = 1'b1;
        step();
        IS_RUNNING = 1'b0;
        ACK = 1'b1;
        step();
        ACK = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("ack_at_expire_alarm", ALARM, 1'b0);
        end

        // ACK in OFF of group 1
        start_expiry();
        run_seq(1, 30);
        ACK = 1'b1;
        step();
        ACK = 1'b0;
        check("ack_lag_alarm", ALARM, 1'b1);
        step();
        check("ack_alarm", ALARM, 1'b0);
        check("ack_beeping", BEEPING, 1'b0);
        check("ack_buzz", BUZZ, 1'b0);
        ACK = 1'b1;
        step();
        ACK = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            check("ack2_alarm", ALARM, 1'b0);
        end

        // Restart during the second group's gap, then a fresh expiry
        start_expiry();
        run_seq(1, 220);
        IS_RUNNING = 1'b1;
        step();
        check("restart_lag_alarm", ALARM, 1'b1);
        step();
        check("restart_alarm", ALARM, 1'b0);
        check("restart_beeping", BEEPING, 1'b0);
        check("restart_buzz", BUZZ, 1'b0);
        start_expiry();
        run_seq(1, 265);

        // CE low for 50 clocks mid-ON; MS_CE toggling is ignored meanwhile
        start_expiry();
        run_seq(1, 14);
        CE = 1'b0;
        for (int i = 0; i < 50; i++) begin
            MS_CE = (i % 2) == 0;
            @(posedge CLK); #1;
            check("freeze_buzz", BUZZ, 1'b1);
            check("freeze_alarm", ALARM, 1'b1);
            check("freeze_beeping", BEEPING, 1'b1);
        end
        MS_CE = 1'b0;
        CE = 1'b1;
        run_seq(15, 265);

        // Asynchronous reset between edges mid-ON
        start_expiry();
        run_seq(1, 50);
        #2 CLR = 1'b0;
        #1;
        check("clr_alarm", ALARM, 1'b0);
        check("clr_beeping", BEEPING, 1'b0);
        check("clr_buzz", BUZZ, 1'b0);
        #1 CLR = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            check("post_clr_alarm", ALARM, 1'b0);
        end
        check("post_clr_buzz", BUZZ, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
